// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles bytes MSB-first into 32-bit words, writes each
// word to memory, then reads it back after RD_LAT clocks and compares it with the buffer.
module imem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        length,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic [31:0]       mem_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              overrun,
    output logic [7:0]        word_count
);

    localparam int unsigned VCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [VCNT_W-1:0] VLAST = VCNT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, VERIFY, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic [7:0]          len_q;
    logic [31:0]         buffer;
    logic [1:0]          byte_cnt;
    logic [VCNT_W-1:0]   vcnt;
    logic [ADDR_W-1:0]   addr;

    logic start_ok;
    logic verify_last;
    logic match;
    logic last_word;

    assign start_ok    = start && (state == IDLE || state == DONE);
    assign verify_last = (state == VERIFY) && (vcnt == VLAST);
    assign match       = (mem_q == buffer);
    // 9-bit compare so word_count+1 cannot wrap into a false match
    assign last_word   = (({1'b0, word_count} + 9'd1) == {1'b0, len_q});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) state_next = (length == 8'd0) ? DONE : COLLECT;
            end
            COLLECT: begin
                if (byte_valid && byte_cnt == 2'd3) state_next = WRITE;
            end
            WRITE: state_next = VERIFY;
            VERIFY: begin
                if (verify_last) begin
                    if (!match || last_word) state_next = DONE;
                    else                     state_next = COLLECT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_wren = (state == WRITE);
        busy     = (state == COLLECT) || (state == WRITE) || (state == VERIFY);
        done     = (state == DONE);
        mem_addr = addr;
        mem_data = buffer;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_q      <= '0;
            buffer     <= '0;
            byte_cnt   <= '0;
            vcnt       <= '0;
            addr       <= '0;
            word_count <= '0;
            err        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        len_q      <= length;
                        byte_cnt   <= '0;
                        vcnt       <= '0;
                        addr       <= '0;
                        word_count <= '0;
                        err        <= 1'b0;
                        overrun    <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (byte_valid) begin
                        buffer   <= {buffer[23:0], byte_in};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                WRITE: begin
                    vcnt <= '0;
                    if (byte_valid) overrun <= 1'b1;
                end
                VERIFY: begin
                    if (byte_valid) overrun <= 1'b1;
                    vcnt <= vcnt + VCNT_W'(1);
                    if (verify_last) begin
                        if (match) begin
                            word_count <= word_count + 8'd1;
                            addr       <= addr + ADDR_W'(1);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: registered-address/registered-output memory models,
// write logging, and hand-computed expectations for each scenario.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        start2;
    logic [7:0]  length;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        corrupt;

    logic [7:0]  mem_addr;
    logic [31:0] mem_data;
    logic [31:0] mem_q;
    logic        mem_wren, busy, done, err, overrun;
    logic [7:0]  word_count;

    logic [1:0]  mem_addr2;
    logic [31:0] mem_data2;
    logic [31:0] mem_q2;
    logic        mem_wren2, busy2, done2, err2, overrun2;
    logic [7:0]  word_count2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    imem_loader #(.ADDR_W(8), .RD_LAT(2)) dut (
        .clock(clock), .reset(reset), .start(start), .length(length),
        .byte_in(byte_in), .byte_valid(byte_valid), .mem_q(mem_q),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .busy(busy), .done(done), .err(err), .overrun(overrun),
        .word_count(word_count)
    );

    imem_loader #(.ADDR_W(2), .RD_LAT(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .length(length),
        .byte_in(byte_in), .byte_valid(byte_valid), .mem_q(mem_q2),
        .mem_addr(mem_addr2), .mem_data(mem_data2), .mem_wren(mem_wren2),
        .busy(busy2), .done(done2), .err(err2), .overrun(overrun2),
        .word_count(word_count2)
    );

    // Memory models: registered address, registered output (2-clock read latency)
    logic [31:0] mem1 [256];
    logic [7:0]  addr_r1;
    logic [31:0] q1;
    logic [31:0] mem2 [4];
    logic [1:0]  addr_r2;
    logic [31:0] q2;

    assign mem_q  = q1 ^ {31'b0, corrupt};
    assign mem_q2 = q2;

    logic [31:0] wd [64];
    logic [7:0]  wa [64];
    int          wn = 0;
    logic [31:0] wd2 [64];
    logic [1:0]  wa2 [64];
    int          wn2 = 0;

    always @(posedge clock) begin
        if (mem_wren) begin
            mem1[mem_addr] <= mem_data;
            wd[wn] <= mem_data;
            wa[wn] <= mem_addr;
            wn     <= wn + 1;
        end
        addr_r1 <= mem_addr;
        q1      <= mem1[addr_r1];
    end

    always @(posedge clock) begin
        if (mem_wren2) begin
            mem2[mem_addr2] <= mem_data2;
            wd2[wn2] <= mem_data2;
            wa2[wn2] <= mem_addr2;
            wn2      <= wn2 + 1;
        end
        addr_r2 <= mem_addr2;
        q2      <= mem2[addr_r2];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic start_dut(input logic [7:0] len);
        length = len;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    int base;

    initial begin
        reset = 1'b1; start = 1'b0; start2 = 1'b0; length = '0;
        byte_in = '0; byte_valid = 1'b0; corrupt = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wren", 32'(mem_wren), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_data", mem_data, 0);
        check("rst_wc",   32'(word_count), 0);
        reset = 1'b0;
        tick(); tick();
        check("idle_no_start", 32'(busy), 0);

        // Two words, correct memory
        base = wn;
        start_dut(8'd2);
        check("t1_busy", 32'(busy), 1);
        send_word(32'h12345678);
        check("t1_wren", 32'(mem_wren), 1);
        check("t1_wdata", mem_data, 32'h12345678);
        check("t1_waddr", 32'(mem_addr), 0);
        tick(); tick(); tick();
        check("t1_wc1", 32'(word_count), 1);
        check("t1_addr1", 32'(mem_addr), 1);
        send_word(32'h9ABCDEF0);
        tick(); tick(); tick();
        check("t1_done", 32'(done), 1);
        check("t1_busy0", 32'(busy), 0);
        check("t1_err", 32'(err), 0);
        check("t1_wc2", 32'(word_count), 2);
        check("t1_nwr", 32'(wn - base), 2);
        check("t1_d0", wd[base], 32'h12345678);
        check("t1_a0", 32'(wa[base]), 0);
        check("t1_d1", wd[base+1], 32'h9ABCDEF0);
        check("t1_a1", 32'(wa[base+1]), 1);

        // Verify mismatch on read-back bit 0
        corrupt = 1'b1;
        start_dut(8'd1);
        send_word(32'h01020304);
        tick(); tick();
        check("t2_notyet", 32'(done), 0);
        tick();
        check("t2_done", 32'(done), 1);
        check("t2_err", 32'(err), 1);
        check("t2_wc", 32'(word_count), 0);
        corrupt = 1'b0;

        // Byte during WRITE is dropped and flags overrun
        base = wn;
        start_dut(8'd2);
        check("t3_errclr", 32'(err), 0);
        send_word(32'h11223344);
        send_byte(8'hEE);
        check("t3_ovr", 32'(overrun), 1);
        tick(); tick();
        send_word(32'h55667788);
        tick(); tick(); tick();
        check("t3_done", 32'(done), 1);
        check("t3_d0", wd[base], 32'h11223344);
        check("t3_d1", wd[base+1], 32'h55667788);
        check("t3_ovr_sticky", 32'(overrun), 1);
        check("t3_wc", 32'(word_count), 2);

        // Reset mid-word aborts without a write
        base = wn;
        start_dut(8'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        reset = 1'b1;
        #1;
        check("t4_busy", 32'(busy), 0);
        check("t4_data", mem_data, 0);
        check("t4_ovr", 32'(overrun), 0);
        check("t4_wc", 32'(word_count), 0);
        tick();
        reset = 1'b0;
        tick(); tick();
        check("t4_idle", 32'(busy), 0);
        check("t4_nowr", 32'(wn - base), 0);
        length = 8'd1; start = 1'b1; byte_in = 8'h99; byte_valid = 1'b1;
        tick();
        start = 1'b0; byte_valid = 1'b0;
        send_word(32'hAABBCCDD);
        tick(); tick(); tick();
        check("t4_done", 32'(done), 1);
        check("t4_nwr", 32'(wn - base), 1);
        check("t4_d0", wd[base], 32'hAABBCCDD);
        check("t4_a0", 32'(wa[base]), 0);
        check("t4_wc1", 32'(word_count), 1);

        // Zero length, then start ignored while busy
        base = wn;
        start_dut(8'd0);
        check("t5_done0", 32'(done), 1);
        check("t5_busy0", 32'(busy), 0);
        start_dut(8'd1);
        send_byte(8'hC0);
        length = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_ignored_busy", 32'(busy), 1);
        check("t5_ignored_done", 32'(done), 0);
        send_byte(8'hC1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        tick(); tick(); tick();
        check("t5_done", 32'(done), 1);
        check("t5_wc", 32'(word_count), 1);
        check("t5_d0", wd[base], 32'hC0C1C2C3);

        // ADDR_W=2 wrap with five words
        base = wn2;
        length = 8'd5; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_word({4{8'(i + 1)}});
            tick(); tick(); tick();
        end
        check("t6_done", 32'(done2), 1);
        check("t6_err", 32'(err2), 0);
        check("t6_wc", 32'(word_count2), 5);
        check("t6_nwr", 32'(wn2 - base), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t6_a%0d", i), 32'(wa2[base+i]), 32'(i % 4));
            check($sformatf("t6_d%0d", i), wd2[base+i], {4{8'(i + 1)}});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
